rom_region_loader: RTL and testbench

//  Consumes the HPS download byte stream and writes it into ROM storage per the LOAD_REGIONS table.

---
 rtl/system_consts_pkg.sv | 50 +++++
 rtl/rom_region_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_rom_region_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/system_consts_pkg.sv
// System-wide constants: ROM load region table and loader state encoding.
package system_consts;

    localparam int unsigned LOAD_REGION_CNT = 9;
    localparam int unsigned LOAD_HDR_BYTES  = 5;

    typedef enum logic [3:0] {
        STORAGE_NONE  = 4'd0,
        STORAGE_SDRAM = 4'd1,
        STORAGE_DDR   = 4'd2,
        STORAGE_BRAM  = 4'd3
    } region_storage_t;

    typedef struct packed {
        logic [31:0]     base_addr;
        region_storage_t storage;
    } region_t;

    localparam region_t LOAD_REGIONS [LOAD_REGION_CNT] = '{
        '{32'h0000_0000, STORAGE_SDRAM},
        '{32'h0090_0000, STORAGE_SDRAM},
        '{32'h3810_0000, STORAGE_DDR},
        '{32'h0000_0000, STORAGE_BRAM},
        '{32'h0000_4000, STORAGE_BRAM},
        '{32'h3800_0000, STORAGE_DDR},
        '{32'h0100_0000, STORAGE_SDRAM},
        '{32'h0000_8000, STORAGE_BRAM},
        '{32'hFFFF_FFFE, STORAGE_DDR}
    };

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_IDX = 3'd1,
        HDR_LEN = 3'd2,
        PAYLOAD = 3'd3,
        WRITE   = 3'd4,
        SKIP    = 3'd5
    } loader_state_t;

    // Out-of-table indices return an all-zero region.
    function automatic region_t region_lookup(input logic [7:0] idx);
        region_t r;
        r = '{base_addr: 32'h0, storage: STORAGE_NONE};
        for (int i = 0; i < int'(LOAD_REGION_CNT); i++) begin
            if (idx == 8'(i)) r = LOAD_REGIONS[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_region_loader.sv
// Parses the download byte stream into region records and emits 16-bit ROM writes.
// Optional LOADER_CHECKSUM_EN: 16-bit wrapping sum of payload bytes on `checksum`.
module rom_region_loader
    import system_consts::*;
#(
    parameter int unsigned NUM_REGIONS = LOAD_REGION_CNT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic [7:0]  dl_data,
    input  logic        dl_valid,
    output logic        dl_ready,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [1:0]  wr_be,
    output logic [3:0]  wr_storage,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);

    localparam logic [2:0] ST_IDLE    = 3'(IDLE);
    localparam logic [2:0] ST_HDR_IDX = 3'(HDR_IDX);
    localparam logic [2:0] ST_HDR_LEN = 3'(HDR_LEN);
    localparam logic [2:0] ST_PAYLOAD = 3'(PAYLOAD);
    localparam logic [2:0] ST_WRITE   = 3'(WRITE);
    localparam logic [2:0] ST_SKIP    = 3'(SKIP);

    logic [2:0]  state_q, state_d;
    logic [7:0]  region_q, region_d;
    logic [31:0] len_q, len_d;
    logic [31:0] offset_q, offset_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  lo_q, lo_d;
    logic        have_lo_q, have_lo_d;
    logic        drop_q, drop_d;
    logic        act_q;
    logic        ready_q, ready_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  be_q, be_d;
    logic [3:0]  stor_q, stor_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        issue;
    logic [31:0] len_full;
    region_t     reg_cur;

    assign accept   = dl_valid & ready_q;
    assign len_full = {dl_data, len_q[31:8]};
    assign reg_cur  = region_lookup(region_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        len_d     = len_q;
        offset_d  = offset_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        have_lo_d = have_lo_q;
        drop_d    = drop_q;
        req_d     = req_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        stor_d    = stor_q;
        done_d    = 1'b0;
        err_d     = err_q;
        issue     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dl_active && !act_q) begin
                    err_d   = 1'b0;
                    state_d = ST_HDR_IDX;
                end
            end
            ST_HDR_IDX: begin
                if (!dl_active) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    region_d = dl_data;
                    len_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_HDR_LEN;
                end
            end
            ST_HDR_LEN: begin
                if (!dl_active) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    len_d = len_full;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(LOAD_HDR_BYTES - 2)) begin
                        if (len_full == 32'd0) begin
                            state_d = ST_HDR_IDX;
                        end else if (32'(region_q) >= NUM_REGIONS) begin
                            err_d   = 1'b1;
                            state_d = ST_SKIP;
                        end else begin
                            offset_d  = '0;
                            have_lo_d = 1'b0;
                            state_d   = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!dl_active) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    len_d = len_q - 32'd1;
                    if (have_lo_q) begin
                        data_d = {dl_data, lo_q};
                        be_d   = 2'b11;
                        issue  = 1'b1;
                    end else if (len_q == 32'd1) begin
                        data_d = {8'h00, dl_data};
                        be_d   = 2'b01;
                        issue  = 1'b1;
                    end else begin
                        lo_d      = dl_data;
                        have_lo_d = 1'b1;
                    end
                end
                if (issue) begin
                    have_lo_d = 1'b0;
                    addr_d    = reg_cur.base_addr + offset_q;
                    stor_d    = reg_cur.storage;
                    req_d     = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A session abort still lets the outstanding write finish.
                if (!dl_active) begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                end
                if (wr_ack) begin
                    req_d    = 1'b0;
                    offset_d = offset_q + 32'd2;
                    drop_d   = 1'b0;
                    if (drop_q || !dl_active) state_d = ST_IDLE;
                    else if (len_q == 32'd0)  state_d = ST_HDR_IDX;
                    else                      state_d = ST_PAYLOAD;
                end
            end
            ST_SKIP: begin
                if (!dl_active) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    len_d = len_q - 32'd1;
                    if (len_q == 32'd1) state_d = ST_HDR_IDX;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_HDR_IDX) || (state_d == ST_HDR_LEN) ||
                  (state_d == ST_PAYLOAD) || (state_d == ST_SKIP);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            region_q  <= '0;
            len_q     <= '0;
            offset_q  <= '0;
            cnt_q     <= '0;
            lo_q      <= '0;
            have_lo_q <= 1'b0;
            drop_q    <= 1'b0;
            act_q     <= 1'b0;
            ready_q   <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            stor_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            len_q     <= len_d;
            offset_q  <= offset_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            have_lo_q <= have_lo_d;
            drop_q    <= drop_d;
            act_q     <= dl_active;
            ready_q   <= ready_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            stor_q    <= stor_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        csum_clr;
    logic        csum_add;

    assign csum_clr = (state_q == ST_IDLE) && dl_active && !act_q;
    assign csum_add = accept && dl_active &&
                      ((state_q == ST_PAYLOAD) || (state_q == ST_SKIP));

    always_comb begin
        csum_d = csum_q;
        if (csum_clr)      csum_d = '0;
        else if (csum_add) csum_d = csum_q + 16'(dl_data);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign dl_ready   = ready_q;
    assign wr_req     = req_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign wr_be      = be_q;
    assign wr_storage = stor_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// Self-checking bench for rom_region_loader: vector table, corner sequences, random sessions.
module tb_rom_region_loader;
    import system_consts::*;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        dl_active;
    logic [7:0]  dl_data;
    logic        dl_valid;
    logic        dl_ready;
    logic        wr_req;
    logic        wr_ack;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [3:0]  wr_storage;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    rom_region_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_data    (dl_data),
        .dl_valid   (dl_valid),
        .dl_ready   (dl_ready),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_storage (wr_storage),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic [3:0]  st;
    } wr_t;

    typedef struct {
        logic [7:0]  idx;
        int          len;
        logic [7:0]  b0, b1, b2, b3;
        int          ack;
        int          nw;
        logic [31:0] a0; logic [15:0] d0; logic [1:0] be0;
        logic [31:0] a1; logic [15:0] d1; logic [1:0] be1;
        logic [3:0]  st;
        logic        err;
        logic [15:0] cs;
    } vec_t;

    // Independent copy of the region table the loader is expected to honour.
    logic [31:0] ref_base [9];
    logic [3:0]  ref_st   [9];

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         got_q [$];
    wr_t         exp_q [$];
    logic [7:0]  stream_q [$];
    logic        exp_err;
    logic [15:0] exp_cs;
    int          ack_dly = 0;
    bit          rand_ack = 1'b0;
    bit          gap_en = 1'b0;
    int          done_cnt = 0;
    logic [15:0] done_cs = '0;
    int          stab_bad = 0;
    int          hold_n = 0;
    int          wait_cnt = 0;
    int          cur_dly = 0;
    wr_t         cap;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void fail_timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no response within bound, expected progress", nm);
    endfunction

    // Write responder: acks after a chosen delay and checks held-stable outputs.
    always @(negedge clk) begin
        wr_t cur;
        if (wr_req) begin
            cur = '{wr_addr, wr_data, wr_be, wr_storage};
            if (dl_ready) stab_bad++;
            if (wait_cnt == 0) begin
                cap     = cur;
                cur_dly = rand_ack ? int'($urandom_range(0, 3)) : ack_dly;
            end else if (cur != cap) begin
                stab_bad++;
            end
            if (wait_cnt >= cur_dly) begin
                wr_ack = 1'b1;
                got_q.push_back(cap);
                hold_n   = wait_cnt + 1;
                wait_cnt = 0;
            end else begin
                wr_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            wr_ack   = rand_ack ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cs = checksum;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                dl_valid = 1'b0;
                dl_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        dl_valid = 1'b1;
        dl_data  = b;
        n = 0;
        while (!dl_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_timeout("byte_accept");
        @(negedge clk);
        dl_valid = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_timeout("busy_drop");
        repeat (2) @(negedge clk);
    endtask

    task automatic run_session();
        int n;
        got_q.delete();
        done_cnt = 0;
        stab_bad = 0;
        hold_n   = 0;
        dl_active = 1'b1;
        foreach (stream_q[i]) send_byte(stream_q[i]);
        n = 0;
        while (!(dl_ready && !wr_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_timeout("session_drain");
        dl_active = 1'b0;
        wait_not_busy();
    endtask

    task automatic push_record(input logic [7:0] idx, input int len);
        stream_q.push_back(idx);
        for (int k = 0; k < 4; k++) stream_q.push_back(8'(len >> (8 * k)));
    endtask

    // Reference: parse the whole stream into expected writes, error flag and byte sum.
    task automatic model_stream();
        int i, idx, len;
        logic [7:0] lo, hi;
        exp_q.delete();
        exp_err = 1'b0;
        exp_cs  = '0;
        i = 0;
        while (i + 5 <= stream_q.size()) begin
            idx = int'(stream_q[i]);
            len = int'(stream_q[i+1]) + (int'(stream_q[i+2]) << 8) +
                  (int'(stream_q[i+3]) << 16) + (int'(stream_q[i+4]) << 24);
            i += 5;
            for (int k = 0; k < len; k++) exp_cs = exp_cs + 16'(stream_q[i+k]);
            if (len != 0 && idx >= 9) exp_err = 1'b1;
            else if (len != 0) begin
                for (int k = 0; k < len; k += 2) begin
                    lo = stream_q[i+k];
                    hi = (k + 1 < len) ? stream_q[i+k+1] : 8'h00;
                    exp_q.push_back('{ref_base[idx] + 32'(k), {hi, lo},
                                      (k + 1 < len) ? 2'b11 : 2'b01, ref_st[idx]});
                end
            end
            i += len;
        end
        if (!CS_EN) exp_cs = '0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    vec_t vt [7];

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ref_base = '{32'h0000_0000, 32'h0090_0000, 32'h3810_0000, 32'h0000_0000, 32'h0000_4000,
                     32'h3800_0000, 32'h0100_0000, 32'h0000_8000, 32'hFFFF_FFFE};
        ref_st   = '{STORAGE_SDRAM, STORAGE_SDRAM, STORAGE_DDR, STORAGE_BRAM, STORAGE_BRAM,
                     STORAGE_DDR, STORAGE_SDRAM, STORAGE_BRAM, STORAGE_DDR};

        //         idx  len b0     b1     b2     b3    ack nw  a0             d0       be0    a1             d1       be1    st             err   cs
        vt[0] = '{8'd0, 4, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 2, 32'h0000_0000, 16'hBBAA, 2'b11, 32'h0000_0002, 16'hDDCC, 2'b11, STORAGE_SDRAM, 1'b0, 16'h030E};
        vt[1] = '{8'd2, 3, 8'h11, 8'h22, 8'h33, 8'h00, 0, 2, 32'h3810_0000, 16'h2211, 2'b11, 32'h3810_0002, 16'h0033, 2'b01, STORAGE_DDR,   1'b0, 16'h0066};
        vt[2] = '{8'd1, 2, 8'h01, 8'h02, 8'h00, 8'h00, 5, 1, 32'h0090_0000, 16'h0201, 2'b11, 32'h0,         16'h0,     2'b00, STORAGE_SDRAM, 1'b0, 16'h0003};
        vt[3] = '{8'd8, 4, 8'h10, 8'h20, 8'h30, 8'h40, 1, 2, 32'hFFFF_FFFE, 16'h2010, 2'b11, 32'h0000_0000, 16'h4030, 2'b11, STORAGE_DDR,   1'b0, 16'h00A0};
        vt[4] = '{8'd9, 2, 8'h05, 8'h06, 8'h00, 8'h00, 0, 0, 32'h0,         16'h0,     2'b00, 32'h0,         16'h0,     2'b00, STORAGE_NONE,  1'b1, 16'h000B};
        vt[5] = '{8'd3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 32'h0,         16'h0,     2'b00, 32'h0,         16'h0,     2'b00, STORAGE_NONE,  1'b0, 16'h0000};
        vt[6] = '{8'd7, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 2, 1, 32'h0000_8000, 16'h005A, 2'b01, 32'h0,         16'h0,     2'b00, STORAGE_BRAM,  1'b0, 16'h005A};

        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_valid  = 1'b0;
        dl_data   = 8'h00;
        wr_ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {dl_ready, wr_req, busy, done, error, wr_be, wr_storage}, '0);
        chk("rst_addr", 64'(wr_addr), 64'h0);
        chk("rst_data", 64'(wr_data), 64'h0);
        chk("rst_csum", 64'(checksum), 64'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready_busy", {dl_ready, busy}, 2'b00);

        // Single-record sessions from the vector table.
        for (int v = 0; v < 7; v++) begin
            ack_dly  = vt[v].ack;
            rand_ack = 1'b0;
            gap_en   = 1'b0;
            stream_q.delete();
            push_record(vt[v].idx, vt[v].len);
            if (vt[v].len > 0) stream_q.push_back(vt[v].b0);
            if (vt[v].len > 1) stream_q.push_back(vt[v].b1);
            if (vt[v].len > 2) stream_q.push_back(vt[v].b2);
            if (vt[v].len > 3) stream_q.push_back(vt[v].b3);
            exp_q.delete();
            if (vt[v].nw > 0) exp_q.push_back('{vt[v].a0, vt[v].d0, vt[v].be0, vt[v].st});
            if (vt[v].nw > 1) exp_q.push_back('{vt[v].a1, vt[v].d1, vt[v].be1, vt[v].st});
            run_session();
            compare_writes($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_error", v), 64'(error), 64'(vt[v].err));
            chk($sformatf("vec%0d_done", v), 64'(done_cnt), 64'd1);
            chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
            chk($sformatf("vec%0d_stable", v), 64'(stab_bad), 64'd0);
            if (vt[v].nw > 0) chk($sformatf("vec%0d_hold", v), 64'(hold_n), 64'(vt[v].ack + 1));
            chk($sformatf("vec%0d_csum", v), 64'(done_cs), CS_EN ? 64'(vt[v].cs) : 64'd0);
        end

        // Invalid index record skipped, following valid record still written.
        ack_dly = 0;
        stream_q.delete();
        push_record(8'd9, 2); stream_q.push_back(8'h77); stream_q.push_back(8'h88);
        push_record(8'd1, 2); stream_q.push_back(8'h01); stream_q.push_back(8'h02);
        exp_q.delete();
        exp_q.push_back('{32'h0090_0000, 16'h0201, 2'b11, STORAGE_SDRAM});
        run_session();
        compare_writes("badidx");
        chk("badidx_error", 64'(error), 64'd1);

        // Session drops mid-payload while a write is outstanding.
        ack_dly = 3;
        got_q.delete();
        done_cnt = 0;
        dl_active = 1'b1;
        send_byte(8'd0);
        send_byte(8'd4); send_byte(8'd0); send_byte(8'd0); send_byte(8'd0);
        send_byte(8'h01); send_byte(8'h02);
        chk("trunc_req_pending", 64'(wr_req), 64'd1);
        dl_active = 1'b0;
        wait_not_busy();
        exp_q.delete();
        exp_q.push_back('{32'h0000_0000, 16'h0201, 2'b11, STORAGE_SDRAM});
        compare_writes("trunc");
        chk("trunc_error", 64'(error), 64'd1);
        chk("trunc_done", 64'(done_cnt), 64'd0);
        chk("trunc_busy", 64'(busy), 64'd0);

        // Checksum over an odd-length payload with a wrapping top byte.
        ack_dly = 0;
        stream_q.delete();
        push_record(8'd0, 3);
        stream_q.push_back(8'h01); stream_q.push_back(8'h02); stream_q.push_back(8'hFF);
        run_session();
        chk("csum_done", 64'(done_cnt), 64'd1);
        chk("csum_value", 64'(done_cs), CS_EN ? 64'h0102 : 64'd0);

        // Asynchronous reset while a write is waiting for ack.
        ack_dly = 20;
        got_q.delete();
        dl_active = 1'b1;
        send_byte(8'd0);
        send_byte(8'd2); send_byte(8'd0); send_byte(8'd0); send_byte(8'd0);
        send_byte(8'hAA); send_byte(8'hBB);
        chk("arst_req_before", 64'(wr_req), 64'd1);
        #3 reset_n = 1'b0;
        #1 chk("arst_req_drop", {wr_req, busy, error, dl_ready}, 4'b0000);
        @(negedge clk);
        dl_active = 1'b0;
        reset_n   = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_no_write", 64'(got_q.size()), 64'd0);
        ack_dly = 0;
        stream_q.delete();
        push_record(8'd4, 2); stream_q.push_back(8'h3C); stream_q.push_back(8'hC3);
        model_stream();
        run_session();
        compare_writes("arst_recover");

        // Randomised multi-record sessions against the stream model.
        rand_ack = 1'b1;
        gap_en   = 1'b1;
        for (int s = 0; s < 12; s++) begin
            stream_q.delete();
            repeat ($urandom_range(1, 3)) begin
                int len;
                len = int'($urandom_range(0, 7));
                push_record(8'($urandom_range(0, 11)), len);
                repeat (len) stream_q.push_back(8'($urandom));
            end
            model_stream();
            run_session();
            compare_writes($sformatf("rnd%0d", s));
            chk($sformatf("rnd%0d_error", s), 64'(error), 64'(exp_err));
            chk($sformatf("rnd%0d_done", s), 64'(done_cnt), 64'd1);
            chk($sformatf("rnd%0d_stable", s), 64'(stab_bad), 64'd0);
            chk($sformatf("rnd%0d_csum", s), 64'(done_cs), 64'(exp_cs));
        end
        rand_ack = 1'b0;
        gap_en   = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
